// File: rtl/axi_vdma_pkg.sv
// Shared definitions for the VDMA AXI write path: FSM encoding, AXI constants
// and the AxSIZE helper.
package axi_vdma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BRESP,
    S_FIN
  } wr_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AxSIZE encoding (log2 of bytes per beat) for a given data bus width in bits.
  function automatic logic [2:0] size_of(input int data_width);
    int bytes;
    logic [2:0] s;
    bytes = data_width / 8;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == bytes) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_wr_burst_exec_beat.sv
// Counts W handshakes within one AXI burst and flags the final beat.
module wr_beat_counter (
  input  logic       clock,
  input  logic       rst,
  input  logic       active,
  input  logic       beat,
  input  logic [8:0] chunk,
  output logic       m_wlast,
  output logic       last_beat
);

  logic [7:0] count;

  // The counter restarts outside the data phase so every burst begins at beat 0.
  always_ff @(posedge clock or posedge rst) begin
    if (rst)                      count <= '0;
    else if (!active || last_beat) count <= '0;
    else if (beat)                count <= count + 8'd1;
  end

  assign m_wlast   = active && (count == 8'(chunk - 9'd1));
  assign last_beat = beat && m_wlast;

endmodule

// File: rtl/axi_wr_burst_exec.sv
// Write-FIFO request responder that turns burst/tail requests into AXI4 INCR
// write bursts. Optional sticky BRESP error flag: define AXI_WR_BRESP_CHECK_EN.
module axi_wr_burst_exec
  import axi_vdma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LSIZE      = 9,
  parameter int MAX_BURST  = 256
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    burst_req,
  input  logic                    tail_req,
  input  logic [LSIZE-1:0]        req_len,
  output logic                    resp,
  output logic                    done,
  input  logic                    frame_start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic                    fifo_empty,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  output logic                    fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic                    err
);

  localparam logic [2:0] AWSIZE = size_of(DATA_WIDTH);

  wr_state_t               state, next_state;
  logic [LSIZE-1:0]        remaining, rem_next;
  logic [ADDR_WIDTH-1:0]   pointer;
  logic [8:0]              chunk;
  logic                    fs_pending;
  logic                    accept;
  logic                    last_beat;

  always_comb begin
    if (int'(remaining) > MAX_BURST) chunk = 9'(MAX_BURST);
    else                             chunk = 9'(remaining);
  end

  assign rem_next = remaining - LSIZE'(chunk);
  // A frame reload in IDLE wins; the held request is taken the following cycle.
  assign accept   = (state == S_IDLE) && (burst_req || tail_req) && !frame_start;

  assign m_awsize   = AWSIZE;
  assign m_awburst  = AXI_BURST_INCR;
  assign m_wstrb    = '1;
  assign m_wdata    = fifo_rd_data;
  assign m_wvalid   = (state == S_DATA) && !fifo_empty;
  assign fifo_rd_en = m_wvalid && m_wready;
  assign m_bready   = (state == S_BRESP);
  assign done       = (state == S_FIN);

  wr_beat_counter u_beat (
    .clock     (clock),
    .rst       (rst),
    .active    (state == S_DATA),
    .beat      (fifo_rd_en),
    .chunk     (chunk),
    .m_wlast   (m_wlast),
    .last_beat (last_beat)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (accept) next_state = (req_len == '0) ? S_FIN : S_ADDR;
      S_ADDR:  if (m_awvalid && m_awready) next_state = S_DATA;
      S_DATA:  if (last_beat) next_state = S_BRESP;
      S_BRESP: if (m_bvalid) next_state = (rem_next != '0) ? S_ADDR : S_FIN;
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: request capture, address pointer, AW channel and deferred frame reload.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      resp       <= 1'b0;
      remaining  <= '0;
      pointer    <= '0;
      fs_pending <= 1'b0;
      m_awvalid  <= 1'b0;
      m_awaddr   <= '0;
      m_awlen    <= '0;
    end else begin
      resp <= accept;
      if (accept) remaining <= req_len;

      if (state == S_BRESP && m_bvalid) begin
        pointer   <= pointer + (ADDR_WIDTH'(chunk) << AWSIZE);
        remaining <= rem_next;
      end else if (state == S_IDLE && frame_start) begin
        pointer <= base_addr;
      end else if (state == S_FIN && (fs_pending || frame_start)) begin
        pointer <= base_addr;
      end

      if (state == S_FIN)                           fs_pending <= 1'b0;
      else if (frame_start && state != S_IDLE)      fs_pending <= 1'b1;

      if (state == S_ADDR && !m_awvalid) begin
        m_awvalid <= 1'b1;
        m_awaddr  <= pointer;
        m_awlen   <= 8'(chunk - 9'd1);
      end else if (m_awvalid && m_awready) begin
        m_awvalid <= 1'b0;
      end
    end
  end

`ifdef AXI_WR_BRESP_CHECK_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst)                                              err <= 1'b0;
    else if (m_bvalid && m_bready && m_bresp != AXI_RESP_OKAY) err <= 1'b1;
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^m_bresp;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_burst_exec.sv
// Scoreboard bench for axi_wr_burst_exec: expected AW/W traffic is queued when a
// request is issued and checked as the DUT hands it over.
module tb_axi_wr_burst_exec;
  import axi_vdma_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LS = 9;
  localparam int MB = 256;
  localparam logic [DW/8-1:0] ALL_ONES = '1;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          burst_req = 1'b0, tail_req = 1'b0;
  logic [LS-1:0] req_len = '0;
  logic          resp, done;
  logic          frame_start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          fifo_empty = 1'b0;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst;
  logic          m_awvalid;
  logic          m_awready = 1'b1;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic          m_wlast, m_wvalid;
  logic          m_wready = 1'b1;
  logic [1:0]    m_bresp = 2'b00;
  logic          m_bvalid = 1'b0;
  logic          m_bready;
  logic          err;

  always #5 clock = ~clock;

  axi_wr_burst_exec #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSIZE(LS), .MAX_BURST(MB)) dut (
    .clock(clock), .rst(rst), .burst_req(burst_req), .tail_req(tail_req), .req_len(req_len),
    .resp(resp), .done(done), .frame_start(frame_start), .base_addr(base_addr),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .err(err)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } aw_exp_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } w_exp_t;

  aw_exp_t     aw_q[$];
  w_exp_t      w_q[$];
  int          tests_run = 0, tests_failed = 0;
  int          resp_count = 0, done_count = 0, beat_count = 0, aw_count = 0, b_pending = 0;
  bit          w_open = 0, resp_prev = 0, done_prev = 0, bresp_err_once = 0;
  int unsigned word_idx = 0, exp_idx = 0;
  logic [AW-1:0] model_ptr = '0;

  function automatic logic [DW-1:0] pattern(input int unsigned i);
    return {~i, i};
  endfunction

  // Write FIFO model: head word is a function of how many words were popped.
  assign fifo_rd_data = pattern(word_idx);
  always @(posedge clock) if (!rst && fifo_rd_en) word_idx <= word_idx + 1;

  // B channel responder: one response per completed burst.
  always @(posedge clock) begin
    #1;
    m_bvalid = !rst && (b_pending > 0);
    m_bresp  = (m_bvalid && bresp_err_once) ? 2'b10 : 2'b00;
  end

  // Monitor and scoreboard compare on the falling edge, away from the DUT's edge.
  always @(negedge clock) begin
    aw_exp_t ea;
    w_exp_t  ew;
    if (rst) begin
      resp_prev = 0;
      done_prev = 0;
    end else begin
      if (resp) begin
        resp_count++;
        tests_run++;
        if (resp_prev) begin tests_failed++; $display("[TB] FAIL resp_width: resp high two cycles, required 1"); end
      end
      if (done) begin
        done_count++;
        tests_run++;
        if (done_prev) begin tests_failed++; $display("[TB] FAIL done_width: done high two cycles, required 1"); end
      end
      resp_prev = resp;
      done_prev = done;
      if (m_awvalid && m_awready) begin
        tests_run++;
        aw_count++;
        if (aw_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL aw_unexpected: addr %0h len %0d, required no AW", m_awaddr, m_awlen);
        end else begin
          ea = aw_q.pop_front();
          if (m_awaddr !== ea.addr || m_awlen !== ea.len) begin
            tests_failed++;
            $display("[TB] FAIL aw: addr %0h len %0d, required addr %0h len %0d", m_awaddr, m_awlen, ea.addr, ea.len);
          end
        end
        if (w_open || b_pending != 0) begin
          tests_failed++;
          $display("[TB] FAIL aw_order: AW issued with previous burst open (w_open %0d b_pending %0d), required 0/0", w_open, b_pending);
        end
        w_open = 1;
      end
      if (m_wvalid && m_wready) begin
        tests_run++;
        beat_count++;
        if (!w_open || !fifo_rd_en) begin
          tests_failed++;
          $display("[TB] FAIL w_handshake: w_open %0d fifo_rd_en %0d, required 1/1", w_open, fifo_rd_en);
        end
        if (w_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL w_unexpected: data %0h, required no beat", m_wdata);
        end else begin
          ew = w_q.pop_front();
          if (m_wdata !== ew.data || m_wlast !== ew.last) begin
            tests_failed++;
            $display("[TB] FAIL w_beat: data %0h last %0d, required data %0h last %0d", m_wdata, m_wlast, ew.data, ew.last);
          end
        end
        if (m_wlast) begin
          w_open = 0;
          b_pending++;
        end
      end
      if (m_bvalid && m_bready) begin
        b_pending--;
        bresp_err_once = 0;
      end
    end
  end

  task automatic push_expect(input int len);
    int rem;
    int c;
    rem = len;
    while (rem > 0) begin
      c = (rem > MB) ? MB : rem;
      aw_q.push_back('{addr: model_ptr, len: 8'(c - 1)});
      for (int i = 0; i < c; i++) begin
        w_q.push_back('{data: pattern(exp_idx), last: (i == c - 1)});
        exp_idx++;
      end
      model_ptr = model_ptr + AW'(c * (DW / 8));
      rem -= c;
    end
  endtask

  task automatic start_request(input bit use_burst, input bit use_tail, input int len,
                               input bit with_fs, input logic [AW-1:0] fs_addr);
    bit seen;
    @(posedge clock); #1;
    burst_req = use_burst;
    tail_req  = use_tail;
    req_len   = LS'(len);
    if (with_fs) begin
      frame_start = 1'b1;
      base_addr   = fs_addr;
      model_ptr   = fs_addr;
    end
    push_expect(len);
    if (with_fs) begin
      @(posedge clock); #1;
      frame_start = 1'b0;
      @(negedge clock);
      tests_run++;
      if (resp !== 1'b0) begin tests_failed++; $display("[TB] FAIL fs_precedence: resp %0d, required 0", resp); end
    end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (resp) seen = 1;
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("[TB] FAIL resp_timeout: resp 0 after 20 cycles, required 1"); end
    @(posedge clock); #1;
    burst_req = 1'b0;
    tail_req  = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int max_cycles);
    bit seen;
    seen = (done_count > d0);
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clock);
      if (done_count > d0) seen = 1;
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("[TB] FAIL done_timeout: no done in %0d cycles, required 1", max_cycles); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    tests_run++;
    if ({resp, done, fifo_rd_en, m_awvalid, m_wvalid, m_wlast, m_bready, err} !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: %b, required 00000000", {resp, done, fifo_rd_en, m_awvalid, m_wvalid, m_wlast, m_bready, err});
    end
    tests_run++;
    if (m_awaddr !== '0 || m_awsize !== 3'd3 || m_awburst !== 2'b01 || m_wstrb !== ALL_ONES) begin
      tests_failed++;
      $display("[TB] FAIL reset_consts: addr %0h size %0d burst %0d strb %0h, required 0 3 1 %0h",
               m_awaddr, m_awsize, m_awburst, m_wstrb, ALL_ONES);
    end
    @(posedge clock); #1;
    rst = 1'b0;
  endtask

  task automatic test_burst_200();
    int r0, d0, b0;
    r0 = resp_count; d0 = done_count; b0 = beat_count;
    start_request(1, 0, 200, 1, 32'h1000_0000);
    wait_done(d0, 1000);
    tests_run++;
    if (beat_count - b0 !== 200 || aw_q.size() !== 0 || w_q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL burst_200: beats %0d aw_left %0d w_left %0d, required 200 0 0", beat_count - b0, aw_q.size(), w_q.size());
    end
    tests_run++;
    if (resp_count - r0 !== 1 || done_count - d0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL burst_200_pulses: resp %0d done %0d, required 1 1", resp_count - r0, done_count - d0);
    end
  endtask

  task automatic test_tail_37();
    int d0, b0;
    d0 = done_count; b0 = beat_count;
    start_request(0, 1, 37, 0, '0);
    wait_done(d0, 500);
    tests_run++;
    if (beat_count - b0 !== 37 || aw_q.size() !== 0 || w_q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL tail_37: beats %0d aw_left %0d w_left %0d, required 37 0 0", beat_count - b0, aw_q.size(), w_q.size());
    end
  endtask

  // Both request levels together, a 300-beat split, and a frame reload arriving mid-burst.
  task automatic test_split_300();
    int r0, d0, a0, b0;
    bit reached;
    r0 = resp_count; d0 = done_count; a0 = aw_count; b0 = beat_count;
    start_request(1, 1, 300, 0, '0);
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clock);
      if (beat_count - b0 >= 20) reached = 1;
    end
    tests_run++;
    if (!reached) begin tests_failed++; $display("[TB] FAIL split_progress: beats %0d, required 20", beat_count - b0); end
    @(posedge clock); #1;
    frame_start = 1'b1;
    base_addr   = 32'h3000_0000;
    @(posedge clock); #1;
    frame_start = 1'b0;
    wait_done(d0, 1500);
    model_ptr = 32'h3000_0000;
    tests_run++;
    if (aw_count - a0 !== 2 || resp_count - r0 !== 1 || done_count - d0 !== 1 || w_q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL split_300: aw %0d resp %0d done %0d w_left %0d, required 2 1 1 0",
               aw_count - a0, resp_count - r0, done_count - d0, w_q.size());
    end
  endtask

  task automatic test_stall();
    int d0, b0, stall_cycles;
    bit stall_done, finished;
    d0 = done_count; b0 = beat_count;
    stall_cycles = 0; stall_done = 0; finished = 0;
    start_request(1, 0, 200, 0, '0);
    for (int i = 0; i < 3000 && !finished; i++) begin
      @(posedge clock); #1;
      m_wready  = 1'($urandom_range(0, 1));
      m_awready = 1'($urandom_range(0, 1));
      if (!stall_done && beat_count - b0 >= 10) begin
        fifo_empty = (stall_cycles < 20);
        if (stall_cycles >= 20) stall_done = 1;
        stall_cycles++;
      end
      @(negedge clock);
      if (fifo_empty) begin
        tests_run++;
        if (m_wvalid !== 1'b0 || fifo_rd_en !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL stall: wvalid %0d rd_en %0d, required 0 0", m_wvalid, fifo_rd_en);
        end
      end
      if (done_count > d0) finished = 1;
    end
    m_wready = 1'b1; m_awready = 1'b1; fifo_empty = 1'b0;
    tests_run++;
    if (!finished || !stall_done || beat_count - b0 !== 200 || w_q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL stall_total: done %0d stalled %0d beats %0d w_left %0d, required 1 1 200 0",
               finished, stall_done, beat_count - b0, w_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int b0, d0;
    bit reached;
    b0 = beat_count;
    start_request(1, 0, 200, 0, '0);
    reached = 0;
    for (int i = 0; i < 400 && !reached; i++) begin
      @(negedge clock);
      if (beat_count - b0 >= 50) reached = 1;
    end
    tests_run++;
    if (!reached) begin tests_failed++; $display("[TB] FAIL reset_mid_progress: beats %0d, required 50", beat_count - b0); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({resp, done, fifo_rd_en, m_awvalid, m_wvalid, m_wlast, m_bready, err} !== 8'h00 || m_awaddr !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_async: ctrl %b addr %0h, required 00000000 0",
               {resp, done, fifo_rd_en, m_awvalid, m_wvalid, m_wlast, m_bready, err}, m_awaddr);
    end
    aw_q.delete();
    w_q.delete();
    w_open = 0;
    b_pending = 0;
    exp_idx = word_idx;
    model_ptr = '0;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    d0 = done_count;
    start_request(1, 0, 4, 0, '0);
    wait_done(d0, 100);
    tests_run++;
    if (aw_q.size() !== 0 || w_q.size() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_restart: aw_left %0d w_left %0d, required 0 0", aw_q.size(), w_q.size());
    end
  endtask

  task automatic test_zero_len();
    int r0, d0, a0;
    r0 = resp_count; d0 = done_count; a0 = aw_count;
    start_request(1, 0, 0, 0, '0);
    wait_done(d0, 20);
    repeat (4) @(negedge clock);
    tests_run++;
    if (aw_count !== a0 || resp_count - r0 !== 1 || done_count - d0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL zero_len: aw %0d resp %0d done %0d, required 0 1 1", aw_count - a0, resp_count - r0, done_count - d0);
    end
  endtask

`ifdef AXI_WR_BRESP_CHECK_EN
  task automatic test_bresp_err();
    int d0, a0;
    d0 = done_count; a0 = aw_count;
    bresp_err_once = 1;
    start_request(1, 0, 300, 0, '0);
    wait_done(d0, 1500);
    repeat (3) @(negedge clock);
    tests_run++;
    if (err !== 1'b1 || aw_count - a0 !== 2 || done_count - d0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL bresp_err: err %0d aw %0d done %0d, required 1 2 1", err, aw_count - a0, done_count - d0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_burst_200();
    test_tail_37();
    test_split_300();
    test_stall();
    test_reset_mid();
    test_zero_len();
`ifdef AXI_WR_BRESP_CHECK_EN
    test_bresp_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
